// File: rtl/barrel_rotate_detect_32.sv
`default_nettype none
// ============================================================================
// Module      : barrel_rotate_detect_32
// Description : Sequential rotation-amount detector. Accepts an original word
//               and a rotated word, then tests one candidate left-rotate
//               amount per clock (0..31). Reports the smallest matching
//               left-rotate amount and the equivalent right-rotate amount,
//               or reports no match.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   request presents ref_data / rot_data
//               in_ready   block can accept a request (IDLE)
//               ref_data   original (unrotated) word, 32 bits
//               rot_data   candidate rotated word, 32 bits
//               out_valid  result available (DONE)
//               out_ready  consumer accepts the result
//               found      some k satisfies rotl(ref, k) == rot
//               left_amt   smallest such k, 0 when not found
//               right_amt  (32 - left_amt) mod 32, 0 when not found
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_rotate_detect_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ref_data,
    input  logic [31:0] rot_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic [4:0]  left_amt,
    output logic [4:0]  right_amt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_ref;
    logic [31:0] r_rot;
    logic [4:0]  r_cnt;
    logic        r_found;
    logic [4:0]  r_left;
    logic [4:0]  r_right;

    logic [4:0]  w_rsh;
    logic [31:0] w_rotl;
    logic        w_match;

    // Right-shift companion of the left shift: (32 - cnt) mod 32. At cnt = 0
    // both shifts are zero and the OR simply returns r_ref, so no special
    // case is needed. The same value is the equivalent right-rotate amount.
    assign w_rsh   = 5'd0 - r_cnt;
    assign w_rotl  = (r_ref << r_cnt) | (r_ref >> w_rsh);
    assign w_match = (w_rotl == r_rot);

    // Handshake flags come straight from the state register so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign found     = r_found;
    assign left_amt  = r_left;
    assign right_amt = r_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ref   <= 32'd0;
            r_rot   <= 32'd0;
            r_cnt   <= 5'd0;
            r_found <= 1'b0;
            r_left  <= 5'd0;
            r_right <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ref   <= ref_data;
                        r_rot   <= rot_data;
                        r_cnt   <= 5'd0;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    // Candidates are tried in ascending order, so the first
                    // hit is the smallest amount for periodic patterns.
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_left  <= r_cnt;
                        r_right <= w_rsh;
                        r_state <= S_DONE;
                    end else if (r_cnt == 5'd31) begin
                        r_found <= 1'b0;
                        r_left  <= 5'd0;
                        r_right <= 5'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barrel_rotate_detect_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_rotate_detect_32
// Description : Self-checking bench for barrel_rotate_detect_32. Expected
//               results are queued when a request is driven and popped when
//               the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_rotate_detect_32;

    typedef struct packed {
        logic       f;
        logic [4:0] l;
        logic [4:0] r;
        logic [7:0] lat;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ref_data;
    logic [31:0] rot_data;
    logic        out_valid;
    logic        out_ready;
    logic        found;
    logic [4:0]  left_amt;
    logic [4:0]  right_amt;

    int   checks;
    int   failures;
    res_t sb[$];

    barrel_rotate_detect_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ref_data  (ref_data),
        .rot_data  (rot_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .left_amt  (left_amt),
        .right_amt (right_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference search: rotate one bit at a time, first hit wins.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        m;
        logic [31:0] t;
        m = '{f: 1'b0, l: 5'd0, r: 5'd0, lat: 8'd32};
        t = a;
        for (int k = 0; k < 32; k++) begin
            if (t == b) begin
                m.f   = 1'b1;
                m.l   = 5'(k);
                m.r   = 5'((32 - k) % 32);
                m.lat = 8'(k + 1);
                return m;
            end
            t = {t[30:0], t[31]};
        end
        return m;
    endfunction

    function automatic res_t mk(input logic f, input int l, input int r, input int lat);
        res_t m;
        m.f = f; m.l = 5'(l); m.r = 5'(r); m.lat = 8'(lat);
        return m;
    endfunction

    // Drives one request, measures latency from the accept edge, pops the
    // expected result. Optionally pulses in_valid mid-search and optionally
    // completes the output handshake.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input res_t e,
                           input bit pulse, input bit do_release,
                           output res_t got, output res_t exp_o);
        int w;
        int lat;
        sb.push_back(e);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        ref_data = a;
        rot_data = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (pulse && lat == 5) begin
                in_valid = 1'b1;
                ref_data = 32'd0;
                rot_data = 32'd0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        got.f   = found;
        got.l   = left_amt;
        got.r   = right_amt;
        got.lat = 8'(lat);
        exp_o   = sb.pop_front();
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ref_data = 32'd0; rot_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, found, left_amt, right_amt} !== {1'b1, 1'b0, 1'b0, 5'd0, 5'd0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b f=%b l=%0d r=%0d, want rdy=1 vld=0 f=0 l=0 r=0",
                     in_ready, out_valid, found, left_amt, right_amt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_patterns();
        logic [31:0] ta[8];
        logic [31:0] tb[8];
        res_t        te[8];
        res_t        got, ex;
        logic [31:0] rnd;
        int          k;
        ta[0] = 32'h0000_0001; tb[0] = 32'h0000_0010; te[0] = mk(1, 4, 28, 5);
        ta[1] = 32'h8000_0001; tb[1] = 32'hC000_0000; te[1] = mk(1, 31, 1, 32);
        ta[2] = 32'hAAAA_AAAA; tb[2] = 32'h5555_5555; te[2] = mk(1, 1, 31, 2);
        ta[3] = 32'h1234_5678; tb[3] = 32'h1234_5678; te[3] = mk(1, 0, 0, 1);
        ta[4] = 32'hF000_000F; tb[4] = 32'h0000_00FF; te[4] = mk(1, 4, 28, 5);
        for (int i = 5; i < 8; i++) begin
            rnd = $urandom();
            k   = $urandom_range(1, 31);
            ta[i] = rnd;
            tb[i] = (rnd << k) | (rnd >> (32 - k));
            te[i] = model(ta[i], tb[i]);
        end
        for (int i = 0; i < 8; i++) begin
            run_req(ta[i], tb[i], te[i], 1'b0, 1'b1, got, ex);
            checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL pattern_%0d: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                         i, got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
            end
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL idle_after_handshake_%0d: got rdy=%b vld=%b, want rdy=1 vld=0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_no_match();
        res_t got, ex;
        run_req(32'h1234_5678, 32'h1234_5679, mk(0, 0, 0, 32), 1'b1, 1'b1, got, ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL no_match: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                     got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
        end
        // A request pulsed during the search must not have been queued.
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL ignored_in_valid: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        res_t got, ex;
        run_req(32'h00F0_0000, 32'h0F00_0000, mk(1, 4, 28, 5), 1'b0, 1'b0, got, ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL bp_result: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                     got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, found, left_amt, right_amt} !== {1'b1, 1'b0, ex.f, ex.l, ex.r}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b f=%b l=%0d r=%0d, want vld=1 rdy=0 f=%b l=%0d r=%0d",
                         c, out_valid, in_ready, found, left_amt, right_amt, ex.f, ex.l, ex.r);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        res_t got, ex;
        run_req(32'hDEAD_BEEF, 32'hBEEF_DEAD, mk(1, 16, 16, 17), 1'b0, 1'b1, got, ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL b2b_first: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                     got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
        end
        run_req(32'h0000_0003, 32'h0000_0006, mk(1, 1, 31, 2), 1'b0, 1'b1, got, ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL b2b_second: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                     got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
        end
    endtask

    task automatic test_reset_abort();
        res_t got, ex;
        // Target would match at k = 20; abort at cnt = 10.
        ref_data = 32'h0000_0001;
        rot_data = 32'h0010_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, found, left_amt, right_amt} !== {1'b1, 1'b0, 1'b0, 5'd0, 5'd0}) begin
            failures++;
            $display("FAIL abort_reset: got rdy=%b vld=%b f=%b l=%0d r=%0d, want rdy=1 vld=0 f=0 l=0 r=0",
                     in_ready, out_valid, found, left_amt, right_amt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(32'h0000_0001, 32'h0000_0080, mk(1, 7, 25, 8), 1'b0, 1'b1, got, ex);
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL after_abort: got f=%b l=%0d r=%0d lat=%0d, want f=%b l=%0d r=%0d lat=%0d",
                     got.f, got.l, got.r, got.lat, ex.f, ex.l, ex.r, ex.lat);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_patterns();
        test_no_match();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
